grf_multiport: RTL and testbench

GRF_MULTIPORT -- requirements
Module: grf_multiport

---
 rtl/grf_multiport.sv | 131 +++++++++++++
 tb/tb_grf_multiport.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/grf_multiport.sv
// grf_multiport -- general register file with two combinational read ports,
// two write ports, a per-register pending scoreboard and a committed-write
// counter.
//
// Ports
//   Clk            single clock, all state changes on the rising edge
//   Reset          synchronous, active-high; clears registers, pending bits
//                  and the write counter
//   RA, RB         read addresses for ports A and B
//   busA, busB     read data (combinational, optional same-cycle forwarding)
//   WE0/RW0/WD0    write port 0 (enable, address, data)
//   WE1/RW1/WD1    write port 1; wins over port 0 on an address collision
//   SbSet, SbAddr  mark a register as pending (a producer was issued)
//   busyA, busyB   pending status of RA and RB
//   WrCnt          16-bit wrapping count of committed writes
//
// Parameters
//   DATA_W   register width
//   ADDR_W   address width, depth is 2**ADDR_W
//   BYPASS   1 = a read sees a write to the same address in the same cycle
//   ZERO_REG 1 = register 0 always reads zero and never becomes pending
module grf_multiport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  output logic [DATA_W-1:0] busA,
  output logic [DATA_W-1:0] busB,
  input  logic              WE0,
  input  logic              WE1,
  input  logic [ADDR_W-1:0] RW0,
  input  logic [ADDR_W-1:0] RW1,
  input  logic [DATA_W-1:0] WD0,
  input  logic [DATA_W-1:0] WD1,
  input  logic              SbSet,
  input  logic [ADDR_W-1:0] SbAddr,
  output logic              busyA,
  output logic              busyB,
  output logic [15:0]       WrCnt
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);
  localparam bit BYP   = (BYPASS != 0);

  logic [DATA_W-1:0] regs_reg  [DEPTH];
  logic [DATA_W-1:0] regs_next [DEPTH];
  logic [DEPTH-1:0]  pending_reg;
  logic [DEPTH-1:0]  pending_next;
  logic [15:0]       wrcnt_reg;
  logic [15:0]       wrcnt_next;

  // A write (or scoreboard set) aimed at the hardwired zero register is
  // dropped entirely: no storage update, no pending change, no count.
  logic eff0;
  logic eff1;
  logic sb_eff;

  assign eff0   = WE0   && !(ZR && (RW0    == '0));
  assign eff1   = WE1   && !(ZR && (RW1    == '0));
  assign sb_eff = SbSet && !(ZR && (SbAddr == '0));

  // Per-register next state. Port 1 is tested first so it overrides port 0
  // on a collision; a scoreboard set beats a clear because the newly issued
  // producer has not written yet.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
      localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
      logic hit0;
      logic hit1;
      assign hit0 = eff0 && (RW0 == IDX);
      assign hit1 = eff1 && (RW1 == IDX);
      assign regs_next[gi]    = hit1 ? WD1 : (hit0 ? WD0 : regs_reg[gi]);
      assign pending_next[gi] = (sb_eff && (SbAddr == IDX)) ? 1'b1 :
                                ((hit0 || hit1) ? 1'b0 : pending_reg[gi]);
    end
  endgenerate

  // Collisions still count twice: the counter tracks port activity.
  assign wrcnt_next = wrcnt_reg + 16'(eff0) + 16'(eff1);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_reg[i] <= '0;
      end
      pending_reg <= '0;
      wrcnt_reg   <= '0;
    end else begin
      regs_reg    <= regs_next;
      pending_reg <= pending_next;
      wrcnt_reg   <= wrcnt_next;
    end
  end

  // Read mux: storage, then forwarding (port 1 last so it has priority),
  // then the zero-register override, which beats everything.
  always_comb begin
    busA = regs_reg[RA];
    busB = regs_reg[RB];
    if (BYP) begin
      if (eff0 && (RW0 == RA)) busA = WD0;
      if (eff1 && (RW1 == RA)) busA = WD1;
      if (eff0 && (RW0 == RB)) busB = WD0;
      if (eff1 && (RW1 == RB)) busB = WD1;
    end
    if (ZR && (RA == '0)) busA = '0;
    if (ZR && (RB == '0)) busB = '0;
  end

  // A same-cycle write resolves the hazard early, unless a new producer is
  // being issued for that register in the same cycle.
  always_comb begin
    busyA = pending_reg[RA];
    busyB = pending_reg[RB];
    if (BYP) begin
      if (((eff0 && (RW0 == RA)) || (eff1 && (RW1 == RA))) &&
          !(sb_eff && (SbAddr == RA))) busyA = 1'b0;
      if (((eff0 && (RW0 == RB)) || (eff1 && (RW1 == RB))) &&
          !(sb_eff && (SbAddr == RB))) busyB = 1'b0;
    end
  end

  assign WrCnt = wrcnt_reg;

endmodule

// File: tb/tb_grf_multiport.sv
// Directed bench for grf_multiport with default parameters (32x32, bypass,
// zero register). A table of single-cycle vectors checks forwarding, port
// priority, the zero register, the scoreboard and the counter; hand-written
// sequences cover mid-sequence reset and counter wraparound.
module tb_grf_multiport;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [4:0]  RA, RB, RW0, RW1, SbAddr;
  logic [31:0] busA, busB, WD0, WD1;
  logic        WE0, WE1, SbSet, busyA, busyB;
  logic [15:0] WrCnt;

  int n_chk  = 0;
  int n_fail = 0;

  grf_multiport dut (
    .Clk(Clk), .Reset(Reset), .RA(RA), .RB(RB), .busA(busA), .busB(busB),
    .WE0(WE0), .WE1(WE1), .RW0(RW0), .RW1(RW1), .WD0(WD0), .WD1(WD1),
    .SbSet(SbSet), .SbAddr(SbAddr), .busyA(busyA), .busyB(busyB),
    .WrCnt(WrCnt)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        we0;
    logic [4:0]  rw0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  rw1;
    logic [31:0] wd1;
    logic        sb;
    logic [4:0]  sba;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] ea;
    logic [31:0] eb;
    logic        ya;
    logic        yb;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit we0, input int rw0, input logic [31:0] wd0,
                              input bit we1, input int rw1, input logic [31:0] wd1,
                              input bit sb, input int sba, input int ra, input int rb,
                              input logic [31:0] ea, input logic [31:0] eb,
                              input bit ya, input bit yb, input int cnt);
    vec_t v;
    v.we0 = we0; v.rw0 = 5'(rw0); v.wd0 = wd0;
    v.we1 = we1; v.rw1 = 5'(rw1); v.wd1 = wd1;
    v.sb  = sb;  v.sba = 5'(sba);
    v.ra  = 5'(ra); v.rb = 5'(rb);
    v.ea  = ea; v.eb = eb; v.ya = ya; v.yb = yb; v.cnt = 16'(cnt);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    WE0 = 0; WE1 = 0; RW0 = 0; RW1 = 0; WD0 = 0; WD1 = 0;
    SbSet = 0; SbAddr = 0;
  endtask

  initial begin
    Reset = 1; RA = 0; RB = 0;
    idle();
    repeat (2) @(posedge Clk);
    #1 Reset = 0; RA = 10; RB = 20;
    #3;
    chk("reset_wrcnt", 32'(WrCnt), 32'h0);
    chk("reset_busA", busA, 32'h0);
    chk("reset_busB", busB, 32'h0);
    chk("reset_busy", {30'b0, busyA, busyB}, 32'h0);

    //             we0 rw0 wd0            we1 rw1 wd1            sb sba ra rb  ea             eb             ya yb cnt
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  3, 7, 32'h0,        32'h0,        0, 0, 0));
    vecs.push_back(mk(1, 3, 32'h12345678, 0, 0, 32'h0,        0, 0,  3, 0, 32'h12345678, 32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  3, 0, 32'h12345678, 32'h0,        0, 0, 1));
    vecs.push_back(mk(1, 7, 32'hAAAA0000, 1, 7, 32'h5555FFFF, 0, 0,  7, 3, 32'h5555FFFF, 32'h12345678, 0, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  7, 3, 32'h5555FFFF, 32'h12345678, 0, 0, 3));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'hFFFFFFFF, 0, 0,  0, 7, 32'h0,        32'h5555FFFF, 0, 0, 3));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  0, 7, 32'h0,        32'h5555FFFF, 0, 0, 3));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 9,  9, 9, 32'h0,        32'h0,        0, 0, 3));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  9, 9, 32'h0,        32'h0,        1, 1, 3));
    vecs.push_back(mk(1, 9, 32'h99,       0, 0, 32'h0,        0, 0,  9, 3, 32'h99,       32'h12345678, 0, 0, 3));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  9, 3, 32'h99,       32'h12345678, 0, 0, 4));
    vecs.push_back(mk(1, 9, 32'h100,      0, 0, 32'h0,        1, 9,  3, 3, 32'h12345678, 32'h12345678, 0, 0, 4));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  9, 9, 32'h100,      32'h100,      1, 1, 5));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 0,  0, 9, 32'h0,        32'h100,      0, 1, 5));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  0, 9, 32'h0,        32'h100,      0, 1, 5));
    vecs.push_back(mk(1, 4, 32'h44,       1, 5, 32'h55,       0, 0,  4, 5, 32'h44,       32'h55,       0, 0, 5));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  4, 5, 32'h44,       32'h55,       0, 0, 7));
    vecs.push_back(mk(1, 0, 32'hDEAD,     1, 6, 32'h66,       0, 0,  0, 6, 32'h0,        32'h66,       0, 0, 7));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  6, 0, 32'h66,       32'h0,        0, 0, 8));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 6,  6, 9, 32'h66,       32'h100,      0, 1, 8));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  6, 9, 32'h66,       32'h100,      1, 1, 8));
    vecs.push_back(mk(0, 0, 32'h0,        1, 6, 32'h77,       0, 0,  6, 9, 32'h77,       32'h100,      0, 1, 8));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  6, 9, 32'h77,       32'h100,      0, 1, 9));

    foreach (vecs[i]) begin
      @(posedge Clk);
      #1;
      WE0 = vecs[i].we0; RW0 = vecs[i].rw0; WD0 = vecs[i].wd0;
      WE1 = vecs[i].we1; RW1 = vecs[i].rw1; WD1 = vecs[i].wd1;
      SbSet = vecs[i].sb; SbAddr = vecs[i].sba;
      RA = vecs[i].ra; RB = vecs[i].rb;
      #3;
      chk($sformatf("v%0d_busA", i), busA, vecs[i].ea);
      chk($sformatf("v%0d_busB", i), busB, vecs[i].eb);
      chk($sformatf("v%0d_busyA", i), 32'(busyA), 32'(vecs[i].ya));
      chk($sformatf("v%0d_busyB", i), 32'(busyB), 32'(vecs[i].yb));
      chk($sformatf("v%0d_wrcnt", i), 32'(WrCnt), 32'(vecs[i].cnt));
      $display("vec %0d: ra=%0d busA=%h rb=%0d busB=%h busy=%b%b wrcnt=%0d",
               i, RA, busA, RB, busB, busyA, busyB, WrCnt);
    end

    // Fill registers 1..31, marking 8/16/24 pending, then reset mid-flight.
    for (int i = 1; i < 32; i++) begin
      @(posedge Clk);
      #1;
      idle();
      WE0 = 1; RW0 = 5'(i); WD0 = 32'h01010101 * 32'(i);
      SbSet = (i % 8 == 0); SbAddr = 5'(i);
    end
    @(posedge Clk);
    #1 idle(); RA = 31; RB = 8;
    #3;
    chk("fill_reg31", busA, 32'h1F1F1F1F);
    chk("fill_pend8", 32'(busyB), 32'h1);
    $display("fill: reg31=%h busyB(8)=%b wrcnt=%0d", busA, busyB, WrCnt);

    @(posedge Clk);
    #1;
    Reset = 1; WE0 = 1; RW0 = 5; WD0 = 32'hCAFE; SbSet = 1; SbAddr = 12;
    RA = 5; RB = 8;
    #3;
    chk("rst_bypass_busA", busA, 32'hCAFE);
    chk("rst_busyB_held", 32'(busyB), 32'h1);
    $display("reset cycle: busA=%h busyB=%b", busA, busyB);
    @(posedge Clk);
    #1 Reset = 0; idle();
    #1;
    chk("post_rst_wrcnt", 32'(WrCnt), 32'h0);
    for (int i = 0; i < 32; i++) begin
      RA = 5'(i); RB = 5'(31 - i);
      #1;
      chk($sformatf("post_rst_busA_%0d", i), busA, 32'h0);
      chk($sformatf("post_rst_busB_%0d", i), busB, 32'h0);
      chk($sformatf("post_rst_busy_%0d", i), {30'b0, busyA, busyB}, 32'h0);
    end
    $display("post reset: all registers and pending bits read zero, wrcnt=%0d", WrCnt);

    // Counter wraparound: 65535 single writes, then one dual write.
    @(posedge Clk);
    #1 idle(); WE0 = 1; RW0 = 1; WD0 = 32'h1;
    repeat (65535) @(posedge Clk);
    #1 idle();
    #3;
    chk("wrcnt_ffff", 32'(WrCnt), 32'hFFFF);
    $display("preload: wrcnt=%h", WrCnt);
    WE0 = 1; RW0 = 2; WD0 = 32'h2; WE1 = 1; RW1 = 3; WD1 = 32'h3;
    @(posedge Clk);
    #1 idle();
    #3;
    chk("wrcnt_wrap", 32'(WrCnt), 32'h0001);
    $display("wrap: wrcnt=%h", WrCnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
